mathb_seq_ctrl: RTL and testbench
=================================

MATHB_SEQ_CTRL -- requirements
Module: mathb_seq_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, TPRAM word-address width.
REQ-002 Parameter: RD_LAT, 1, TPRAM read latency in cycles (1..4).
REQ-003 Parameter: MAC_LAT, 2, cycles from last accumulate-enabled cycle to valid FMATHB_EFPGA_MAC_OUT.
REQ-004 EFPGA2MATHB_CLK  in  1  sole clock; all flops rising-edge.
REQ-005 acc_ff_rstn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first operand/coefficient word address.
REQ-008 length  in  ADDR_W  number of operand/coefficient pairs to accumulate.
REQ-009 mode  in  2  MAC width select: 00 x32, 01 x16, 10 x8, 11 x4.
REQ-010 abort  in  1  terminate active job.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 res_data  out  32  captured MAC result.
REQ-014 TPRAM_R_EN  out  1  read strobe for both TPRAM ports.
REQ-015 TPRAM_OPER_R_ADDR, TPRAM_COEF_R_ADDR  out  ADDR_W  read addresses (always equal).
REQ-016 EFPGA_MATHB_OPER_defPin, EFPGA_MATHB_COEF_defPin  out  2  tied to 2'b11.
REQ-017 EFPGA_MATHB_OPER_SEL, EFPGA_MATHB_COEF_SEL  out  1  equal to busy (TPRAM source while busy).
REQ-018 EFPGA_MATHB_CLK_EN  out  1  accumulator enable.
REQ-019 EFPGA_MATHB_MAC_ACC_CLEAR  out  1  accumulator clear.
REQ-020 EFPGA_MATHB_DATAOUT_SEL  out  2  latched mode, held for the whole job.
REQ-021 FMATHB_EFPGA_MAC_OUT  in  32  registered math-block result.

Function
REQ-022 FSM states SHALL be IDLE, CLEAR, FETCH, DRAIN, RESULT.
REQ-023 IDLE: start=1 and length!=0 -> latch base_addr/length/mode, go CLEAR; start=1 and length=0 -> res_data=0, go RESULT; start ignored in all other states.
REQ-024 CLEAR (1 cycle): ACC_CLEAR=1, CLK_EN=1, TPRAM_R_EN=1 at base; next FETCH if length>1, else DRAIN.
REQ-025 FETCH: one read per cycle at base+i, i=1..length-1; go DRAIN after issuing i=length-1.
REQ-026 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-027 CLK_EN outside CLEAR SHALL equal TPRAM_R_EN delayed RD_LAT cycles (one accumulate per pair, no gaps).
REQ-028 DRAIN SHALL last exactly RD_LAT+MAC_LAT cycles; on its final edge res_data <= FMATHB_EFPGA_MAC_OUT, go RESULT.
REQ-029 res_valid first high after edge E(length+RD_LAT+MAC_LAT), where E0 is the edge sampling start.
REQ-030 RESULT: res_valid=1, res_data stable until res_valid&res_ready, then IDLE the next cycle.
REQ-031 abort in CLEAR/FETCH/DRAIN/RESULT: IDLE next cycle; no result; res_valid, TPRAM_R_EN, and CLK_EN (including delayed pipeline) low from the next cycle.
REQ-032 abort and res_ready both high in RESULT: treated as accepted handshake.

Reset
REQ-033 acc_ff_rstn low: state IDLE, busy=0, res_valid=0, res_data=0, TPRAM_R_EN=0, addresses 0, CLK_EN=0, ACC_CLEAR=0, DATAOUT_SEL=00, enable pipeline cleared; async assert, sync deassert; effective mid-job with no result produced.

Verification
REQ-034 base=0, length=4, mode=00, oper={1,2,3,4}, coef={5,6,7,8} -> res_data=70, res_valid rises after E7, CLK_EN high 5 cycles (clear+4).
REQ-035 base=1022, length=4 -> read addresses 1022,1023,0,1 on consecutive cycles.
REQ-036 length=0, start -> res_valid next cycle, res_data=0, no TPRAM_R_EN, no CLK_EN.
REQ-037 res_ready low 5 cycles in RESULT, start pulsed -> res_valid/res_data stable, start ignored, IDLE one cycle after res_ready.
REQ-038 abort in 2nd FETCH cycle of length=8 -> IDLE next cycle, no res_valid, CLK_EN low from next cycle.
REQ-039 acc_ff_rstn low in DRAIN -> all outputs reset immediately; new job afterwards returns correct sum.

Source files
------------

// File: rtl/mathb_seq_ctrl.sv
// Job sequencer for the eFPGA math block: streams operand/coefficient pairs out of
// the TPRAMs into the MAC, waits out the read and MAC latency, then holds the result.
module mathb_seq_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              EFPGA2MATHB_CLK,
  input  logic              acc_ff_rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [1:0]        mode,
  input  logic              abort,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              TPRAM_R_EN,
  output logic [ADDR_W-1:0] TPRAM_OPER_R_ADDR,
  output logic [ADDR_W-1:0] TPRAM_COEF_R_ADDR,
  output logic [1:0]        EFPGA_MATHB_OPER_defPin,
  output logic [1:0]        EFPGA_MATHB_COEF_defPin,
  output logic              EFPGA_MATHB_OPER_SEL,
  output logic              EFPGA_MATHB_COEF_SEL,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              EFPGA_MATHB_MAC_ACC_CLEAR,
  output logic [1:0]        EFPGA_MATHB_DATAOUT_SEL,
  input  logic [31:0]       FMATHB_EFPGA_MAC_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FETCH  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(RD_LAT + MAC_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          dcnt_q, dcnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         res_data_q, res_data_d;
  logic [RD_LAT-1:0]   en_pipe_q, en_pipe_d;
  logic                ren;
  logic                clr;
  logic                abort_act;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    mode_d     = mode_q;
    res_data_d = res_data_q;
    ren        = 1'b0;
    clr        = 1'b0;
    abort_act  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          if (length != '0) begin
            addr_d  = base_addr;
            cnt_d   = length - ADDR_W'(1);
            state_d = CLEAR;
          end else begin
            res_data_d = '0;
            state_d    = RESULT;
          end
        end
      end
      CLEAR, FETCH: begin
        // cnt_q counts reads still to issue after the one on the bus this cycle
        ren = 1'b1;
        clr = (state_q == CLEAR);
        if (cnt_q != '0) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = FETCH;
        end else begin
          dcnt_d  = DRAIN_LAST;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt_q == '0) begin
          res_data_d = FMATHB_EFPGA_MAC_OUT;
          state_d    = RESULT;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any capture; in RESULT it is indistinguishable from an accept
    if (abort && (state_q != IDLE)) begin
      abort_act  = 1'b1;
      state_d    = IDLE;
      res_data_d = res_data_q;
    end

    en_pipe_d    = en_pipe_q;
    en_pipe_d[0] = ren;
    for (int k = 1; k < RD_LAT; k++) en_pipe_d[k] = en_pipe_q[k-1];
    if (abort_act) en_pipe_d = '0;
  end

  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      mode_q     <= 2'b00;
      res_data_q <= '0;
      en_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      mode_q     <= mode_d;
      res_data_q <= res_data_d;
      en_pipe_q  <= en_pipe_d;
    end
  end

  assign busy                      = (state_q != IDLE);
  assign res_valid                 = (state_q == RESULT);
  assign res_data                  = res_data_q;
  assign TPRAM_R_EN                = ren;
  assign TPRAM_OPER_R_ADDR         = addr_q;
  assign TPRAM_COEF_R_ADDR         = addr_q;
  assign EFPGA_MATHB_OPER_defPin   = 2'b11;
  assign EFPGA_MATHB_COEF_defPin   = 2'b11;
  assign EFPGA_MATHB_OPER_SEL      = busy;
  assign EFPGA_MATHB_COEF_SEL      = busy;
  // The clear cycle enables the accumulator itself; afterwards it follows read data
  assign EFPGA_MATHB_CLK_EN        = clr | en_pipe_q[RD_LAT-1];
  assign EFPGA_MATHB_MAC_ACC_CLEAR = clr;
  assign EFPGA_MATHB_DATAOUT_SEL   = mode_q;

endmodule

// File: tb/tb_mathb_seq_ctrl.sv
// Bench for mathb_seq_ctrl: TPRAM/MAC environment model plus a sum-of-products reference.
module tb_mathb_seq_ctrl;
  localparam int ADDR_W  = 10;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, res_ready;
  logic [ADDR_W-1:0] base_addr, length;
  logic [1:0]        mode;
  logic              busy, res_valid;
  logic [31:0]       res_data;
  logic              ren;
  logic [ADDR_W-1:0] oper_addr, coef_addr;
  logic [1:0]        oper_def, coef_def;
  logic              oper_sel, coef_sel;
  logic              clk_en, acc_clear;
  logic [1:0]        dataout_sel;
  logic [31:0]       mac_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] oper_mem [DEPTH];
  logic [31:0] coef_mem [DEPTH];

  always #5 clk = ~clk;

  mathb_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
    .EFPGA2MATHB_CLK          (clk),
    .acc_ff_rstn              (rst_n),
    .start                    (start),
    .base_addr                (base_addr),
    .length                   (length),
    .mode                     (mode),
    .abort                    (abort),
    .busy                     (busy),
    .res_valid                (res_valid),
    .res_ready                (res_ready),
    .res_data                 (res_data),
    .TPRAM_R_EN               (ren),
    .TPRAM_OPER_R_ADDR        (oper_addr),
    .TPRAM_COEF_R_ADDR        (coef_addr),
    .EFPGA_MATHB_OPER_defPin  (oper_def),
    .EFPGA_MATHB_COEF_defPin  (coef_def),
    .EFPGA_MATHB_OPER_SEL     (oper_sel),
    .EFPGA_MATHB_COEF_SEL     (coef_sel),
    .EFPGA_MATHB_CLK_EN       (clk_en),
    .EFPGA_MATHB_MAC_ACC_CLEAR(acc_clear),
    .EFPGA_MATHB_DATAOUT_SEL  (dataout_sel),
    .FMATHB_EFPGA_MAC_OUT     (mac_out)
  );

  // Environment: TPRAM with RD_LAT read latency feeding a MAC whose output is one
  // register behind the accumulator (MAC_LAT = 2).
  logic [ADDR_W-1:0] apipe [RD_LAT];
  logic [31:0]       acc = '0;
  logic [31:0]       mac_out_q = '0;
  always @(posedge clk) begin
    apipe[0] <= oper_addr;
    for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
    if (clk_en) acc <= acc_clear ? 32'd0 : acc + oper_mem[apipe[RD_LAT-1]] * coef_mem[apipe[RD_LAT-1]];
    mac_out_q <= acc;
  end
  assign mac_out = mac_out_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum(input logic [ADDR_W-1:0] b, input int len);
    logic [31:0] s = 0;
    for (int i = 0; i < len; i++) begin
      int a = (int'(b) + i) % DEPTH;
      s += oper_mem[a] * coef_mem[a];
    end
    return s;
  endfunction

  task automatic do_job(input logic [ADDR_W-1:0] b, input int len, input logic [1:0] md,
                        input int rdy_dly, input bit pulse_start);
    int idx = 0, clken_cnt = 0, clr_cnt = 0;
    logic [ADDR_W-1:0] addrs[$];
    bit got = 0, sel_ok = 1, stable = 1;
    logic [31:0] held;
    logic [31:0] exp_sum = ref_sum(b, len);
    @(negedge clk);
    start = 1; base_addr = b; length = ADDR_W'(len); mode = md;
    @(posedge clk);
    @(negedge clk);
    start = 0; base_addr = ADDR_W'($urandom); length = ADDR_W'($urandom); mode = 2'($urandom);
    while (idx < 300) begin
      if (res_valid) begin got = 1; break; end
      if (ren) addrs.push_back(oper_addr);
      if (ren && coef_addr != oper_addr) sel_ok = 0;
      if (clk_en) clken_cnt++;
      if (acc_clear) clr_cnt++;
      if (dataout_sel != md || !busy || !oper_sel || !coef_sel) sel_ok = 0;
      @(negedge clk);
      idx++;
    end
    chk("valid_seen", 32'(got), 32'd1);
    chk("valid_cycle", idx, (len == 0) ? 0 : len + RD_LAT + MAC_LAT);
    chk("res_data", res_data, exp_sum);
    chk("rd_count", addrs.size(), len);
    for (int i = 0; i < addrs.size() && i < len; i++)
      chk("rd_addr", 32'(addrs[i]), (int'(b) + i) % DEPTH);
    chk("clk_en_cycles", clken_cnt, (len == 0) ? 0 : len + 1);
    chk("acc_clear_cycles", clr_cnt, (len == 0) ? 0 : 1);
    chk("sel_mode_hold", 32'(sel_ok), 32'd1);
    held = res_data;
    for (int d = 0; d < rdy_dly; d++) begin
      if (pulse_start && d == 1) begin start = 1; length = 10'd5; base_addr = 10'd7; end
      @(negedge clk);
      start = 0;
      if (!res_valid || res_data !== held || ren || clk_en) stable = 0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("idle_after_ack", 32'(busy), 32'd0);
    chk("valid_after_ack", 32'(res_valid), 32'd0);
    if (pulse_start) begin
      @(negedge clk);
      chk("start_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int bad;
    rst_n = 0; start = 0; abort = 0; res_ready = 0;
    base_addr = '0; length = '0; mode = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oper_mem[i] = $urandom;
      coef_mem[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", res_data, 0);
    chk("rst_ren", 32'(ren), 0);
    chk("rst_addr", 32'(oper_addr), 0);
    chk("rst_clk_en", 32'(clk_en), 0);
    chk("rst_clear", 32'(acc_clear), 0);
    chk("rst_dsel", 32'(dataout_sel), 0);
    chk("defpins", {28'd0, oper_def, coef_def}, 32'hF);
    chk("rst_sel", {30'd0, oper_sel, coef_sel}, 0);
    rst_n = 1;
    @(negedge clk);

    // Small known dot product
    for (int i = 0; i < 4; i++) begin
      oper_mem[i] = 32'(i + 1);
      coef_mem[i] = 32'(i + 5);
    end
    do_job(10'd0, 4, 2'b00, 0, 0);
    chk("known_sum70", res_data, 32'd70);

    // Address wrap at the top of the RAM
    do_job(10'd1022, 4, 2'b01, 1, 0);

    // Zero-length job
    do_job(10'd100, 0, 2'b10, 0, 0);

    // Result back-pressure with a start pulse that must be ignored
    do_job(10'd50, 3, 2'b11, 5, 1);

    // Abort in the second FETCH cycle
    @(negedge clk);
    start = 1; base_addr = 10'd200; length = 10'd8; mode = 2'b00;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ren", 32'(ren), 0);
    chk("abort_clk_en", 32'(clk_en), 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid || clk_en || ren || busy) bad++;
      @(negedge clk);
    end
    chk("abort_quiet", bad, 0);

    // Reset asserted in DRAIN
    @(negedge clk);
    start = 1; base_addr = 10'd300; length = 10'd4; mode = 2'b10;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_in_drain", {31'd0, busy & ~ren & ~res_valid}, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_clk_en", 32'(clk_en), 0);
    chk("mid_rst_dsel", 32'(dataout_sel), 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid || busy) bad++;
    end
    chk("no_result_after_rst", bad, 0);
    do_job(10'd300, 4, 2'b01, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 16; j++) begin
      int len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      do_job(ADDR_W'($urandom), len, 2'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
